// File: rtl/imem_access_ctrl_if.sv
// Bundle of the fetch, loader and RAM-macro signals around the instruction-memory controller.
// The controller takes the slave view; requesters and the RAM model take the master view.
interface imem_access_ctrl_if #(
    parameter int unsigned AW = 10
);
    localparam int unsigned DW = 32;

    // Fetch port (read-only)
    logic          fetch_req_valid;
    logic          fetch_req_ready;
    logic [DW-1:0] fetch_addr;
    logic          fetch_rsp_valid;
    logic [DW-1:0] fetch_rsp_data;
    logic          fetch_rsp_err;

    // Loader / debug port (read/write)
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic          ld_we;
    logic [DW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_rsp_valid;
    logic [DW-1:0] ld_rsp_rdata;
    logic          ld_rsp_err;

    // Single-port synchronous RAM macro
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          init_busy;

    modport slave (
        input  fetch_req_valid, fetch_addr,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  ld_req_valid, ld_we, ld_addr, ld_wdata,
        output ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output init_busy
    );

    modport master (
        output fetch_req_valid, fetch_addr,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output ld_req_valid, ld_we, ld_addr, ld_wdata,
        input  ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  init_busy
    );
endinterface

// File: rtl/imem_access_ctrl.sv
// Shares one single-port instruction RAM between the fetch port and the loader port,
// with an optional post-reset clear, range checking and a fetch anti-starvation limit.
module imem_access_ctrl #(
    parameter int unsigned DEPTH              = 1024,
    parameter int unsigned AW                 = 10,
    parameter int unsigned CLEAR_ON_RESET     = 1,
    parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_access_ctrl_if.slave    bus
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam state_e        RESET_STATE  = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(FETCH_STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX   = {SW{1'b1}};
    localparam logic [AW-1:0] LAST_ADDR    = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clear_ptr_q, clear_ptr_d;
    logic [SW-1:0] starve_q, starve_d;

    // Response tag: who owns the access accepted last cycle and how to answer it
    logic tag_valid_q, tag_valid_d;
    logic tag_ld_q, tag_ld_d;
    logic tag_we_q, tag_we_d;
    logic tag_err_q, tag_err_d;

    logic          run_c;
    logic          clearing_c;
    logic          fetch_oor_c;
    logic          ld_oor_c;
    logic          fetch_pri_c;
    logic          grant_ld_c;
    logic          grant_fetch_c;
    logic          rsp_live_c;

    function automatic logic out_of_range(input logic [DW-1:0] addr);
        return (addr >> (AW + 2)) != '0;
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [DW-1:0] addr);
        return addr[AW+1:2];
    endfunction

    // Arbitration: loader first, unless fetch has waited through STARVE_LIMIT loader grants
    always_comb begin
        run_c         = (state_q == ST_RUN) && !reset;
        clearing_c    = (state_q == ST_INIT) && !reset;
        fetch_oor_c   = out_of_range(bus.fetch_addr);
        ld_oor_c      = out_of_range(bus.ld_addr);
        fetch_pri_c   = bus.fetch_req_valid && (starve_q == STARVE_LIMIT);
        grant_ld_c    = run_c && bus.ld_req_valid && !fetch_pri_c;
        grant_fetch_c = run_c && bus.fetch_req_valid && !grant_ld_c;

        bus.ld_req_ready    = grant_ld_c;
        bus.fetch_req_ready = grant_fetch_c;
    end

    // RAM drive follows the clear pointer during INIT, otherwise the granted request
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (clearing_c) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = clear_ptr_q;
        end else if (grant_ld_c) begin
            if (!ld_oor_c) begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = bus.ld_we;
                bus.mem_addr = word_addr(bus.ld_addr);
                if (bus.ld_we) begin
                    bus.mem_wdata = bus.ld_wdata;
                end
            end
        end else if (grant_fetch_c) begin
            if (!fetch_oor_c) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_addr(bus.fetch_addr);
            end
        end
    end

    // Next-state: clear sequencing, starvation counter and response tag capture
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        starve_d    = starve_q;
        tag_valid_d = 1'b0;
        tag_ld_d    = 1'b0;
        tag_we_d    = 1'b0;
        tag_err_d   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (clear_ptr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    clear_ptr_d = '0;
                end else begin
                    clear_ptr_d = clear_ptr_q + AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (!bus.fetch_req_valid || grant_fetch_c) begin
            starve_d = '0;
        end else if (grant_ld_c && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        if (grant_ld_c) begin
            tag_valid_d = 1'b1;
            tag_ld_d    = 1'b1;
            tag_we_d    = bus.ld_we;
            tag_err_d   = ld_oor_c;
        end else if (grant_fetch_c) begin
            tag_valid_d = 1'b1;
            tag_err_d   = fetch_oor_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            clear_ptr_q <= '0;
            starve_q    <= '0;
            tag_valid_q <= 1'b0;
            tag_ld_q    <= 1'b0;
            tag_we_q    <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            starve_q    <= starve_d;
            tag_valid_q <= tag_valid_d;
            tag_ld_q    <= tag_ld_d;
            tag_we_q    <= tag_we_d;
            tag_err_q   <= tag_err_d;
        end
    end

    // Responses: routed by the tag; read data comes straight from the RAM output register
    always_comb begin
        rsp_live_c = tag_valid_q && !reset;

        bus.fetch_rsp_valid = rsp_live_c && !tag_ld_q;
        bus.fetch_rsp_err   = rsp_live_c && !tag_ld_q && tag_err_q;
        bus.fetch_rsp_data  = '0;
        if (rsp_live_c && !tag_ld_q && !tag_err_q) begin
            bus.fetch_rsp_data = bus.mem_rdata;
        end

        bus.ld_rsp_valid = rsp_live_c && tag_ld_q;
        bus.ld_rsp_err   = rsp_live_c && tag_ld_q && tag_err_q;
        bus.ld_rsp_rdata = '0;
        if (rsp_live_c && tag_ld_q && !tag_we_q && !tag_err_q) begin
            bus.ld_rsp_rdata = bus.mem_rdata;
        end

        bus.init_busy = reset ? (CLEAR_ON_RESET != 0) : (state_q == ST_INIT);
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: vector table for grants and RAM drive, response scoreboard,
// hand-written sequences for the clear phase, mid-operation reset and the no-clear build.
module tb_imem_access_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b0;
    always #5 clk = ~clk;

    imem_access_ctrl_if #(.AW(AW)) bif ();
    imem_access_ctrl_if #(.AW(AW)) bif0 ();

    imem_access_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .CLEAR_ON_RESET(1), .FETCH_STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    imem_access_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .CLEAR_ON_RESET(0), .FETCH_STARVE_LIMIT(LIMIT)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bif0)
    );

    // Behavioural single-port synchronous RAMs, preloaded with non-zero garbage
    logic [31:0] ram  [DEPTH];
    logic [31:0] ram0 [DEPTH];
    logic [31:0] rdata, rdata0;
    assign bif.mem_rdata  = rdata;
    assign bif0.mem_rdata = rdata0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ram[i]  <= 32'hBAD0_0000 | 32'(i);
                ram0[i] <= 32'hA000_0000 | 32'(i);
            end
        end else begin
            if (bif.mem_en) begin
                if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
                else rdata <= ram[bif.mem_addr];
            end
            if (bif0.mem_en) begin
                if (bif0.mem_we) ram0[bif0.mem_addr] <= bif0.mem_wdata;
                else rdata0 <= ram0[bif0.mem_addr];
            end
        end
    end

    typedef struct {
        string       nm;
        logic        fv;
        logic [31:0] fa;
        logic        lv;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        e_fr;
        logic        e_lr;
        logic        e_en;
        logic        e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    typedef struct {
        logic        ld;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        sbq [$];
    vec_t        tbl [$];
    logic [31:0] shadow [DEPTH];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic vec_t mk(input string nm, input logic fv, input logic [31:0] fa,
                                input logic lv, input logic lwe, input logic [31:0] la,
                                input logic [31:0] lwd, input logic efr, input logic elr,
                                input logic een, input logic ewe, input logic [AW-1:0] ea);
        vec_t v;
        v.nm = nm; v.fv = fv; v.fa = fa; v.lv = lv; v.lwe = lwe; v.la = la; v.lwd = lwd;
        v.e_fr = efr; v.e_lr = elr; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
        return v;
    endfunction

    function automatic logic oor(input logic [31:0] a);
        return a >= (32'd4 * 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] wordof(input logic [31:0] a);
        return AW'(a / 32'd4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_idle();
        bif.fetch_req_valid = 1'b0; bif.fetch_addr = '0;
        bif.ld_req_valid = 1'b0; bif.ld_we = 1'b0; bif.ld_addr = '0; bif.ld_wdata = '0;
    endtask

    // Compare the response channels against the scoreboard head (or against silence)
    task automatic check_rsp(input string nm);
        rsp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.ld) begin
                chk({nm, " ld_rsp_valid"}, 32'(bif.ld_rsp_valid), 32'd1);
                chk({nm, " fetch_rsp_valid"}, 32'(bif.fetch_rsp_valid), 32'd0);
                chk({nm, " ld_rsp_rdata"}, bif.ld_rsp_rdata, e.data);
                chk({nm, " ld_rsp_err"}, 32'(bif.ld_rsp_err), 32'(e.err));
            end else begin
                chk({nm, " fetch_rsp_valid"}, 32'(bif.fetch_rsp_valid), 32'd1);
                chk({nm, " ld_rsp_valid"}, 32'(bif.ld_rsp_valid), 32'd0);
                chk({nm, " fetch_rsp_data"}, bif.fetch_rsp_data, e.data);
                chk({nm, " fetch_rsp_err"}, 32'(bif.fetch_rsp_err), 32'(e.err));
            end
        end else begin
            chk({nm, " idle fetch_rsp_valid"}, 32'(bif.fetch_rsp_valid), 32'd0);
            chk({nm, " idle ld_rsp_valid"}, 32'(bif.ld_rsp_valid), 32'd0);
        end
    endtask

    // One cycle: drive just after the edge, check on the falling edge, queue the response
    task automatic step(input vec_t v);
        rsp_t        e;
        logic [31:0] a;
        bif.fetch_req_valid = v.fv; bif.fetch_addr = v.fa;
        bif.ld_req_valid = v.lv; bif.ld_we = v.lwe; bif.ld_addr = v.la; bif.ld_wdata = v.lwd;
        @(negedge clk);
        check_rsp(v.nm);
        chk({v.nm, " fetch_req_ready"}, 32'(bif.fetch_req_ready), 32'(v.e_fr));
        chk({v.nm, " ld_req_ready"}, 32'(bif.ld_req_ready), 32'(v.e_lr));
        chk({v.nm, " mem_en"}, 32'(bif.mem_en), 32'(v.e_en));
        if (v.e_en) begin
            chk({v.nm, " mem_we"}, 32'(bif.mem_we), 32'(v.e_we));
            chk({v.nm, " mem_addr"}, 32'(bif.mem_addr), 32'(v.e_addr));
            if (v.e_we) chk({v.nm, " mem_wdata"}, bif.mem_wdata, v.lwd);
        end
        if (v.e_fr || v.e_lr) begin
            e.ld  = v.e_lr;
            a     = v.e_lr ? v.la : v.fa;
            e.err = oor(a);
            e.data = (e.err || (v.e_lr && v.lwe)) ? 32'd0 : shadow[wordof(a)];
            if (v.e_lr && v.lwe && !e.err) shadow[wordof(a)] = v.lwd;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input string nm);
        step(mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        logic f;
        drive_idle();
        bif0.fetch_req_valid = 1'b1; bif0.fetch_addr = 32'h4;
        bif0.ld_req_valid = 1'b0; bif0.ld_we = 1'b0; bif0.ld_addr = '0; bif0.ld_wdata = '0;
        bif.fetch_req_valid = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
        preload = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;

        @(negedge clk);
        chk("rst init_busy", 32'(bif.init_busy), 32'd1);
        chk("rst fetch_req_ready", 32'(bif.fetch_req_ready), 32'd0);
        chk("rst ld_req_ready", 32'(bif.ld_req_ready), 32'd0);
        chk("rst mem_en", 32'(bif.mem_en), 32'd0);
        chk("rst mem_we", 32'(bif.mem_we), 32'd0);
        chk("rst fetch_rsp_valid", 32'(bif.fetch_rsp_valid), 32'd0);
        chk("rst0 init_busy", 32'(bif0.init_busy), 32'd0);
        chk("rst0 fetch_req_ready", 32'(bif0.fetch_req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear phase with a fetch waiting the whole time
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clk);
            chk("init init_busy", 32'(bif.init_busy), 32'd1);
            chk("init mem_en", 32'(bif.mem_en), 32'd1);
            chk("init mem_we", 32'(bif.mem_we), 32'd1);
            chk("init mem_addr", 32'(bif.mem_addr), 32'(k));
            chk("init mem_wdata", bif.mem_wdata, 32'd0);
            chk("init fetch_req_ready", 32'(bif.fetch_req_ready), 32'd0);
            chk("init0 init_busy", 32'(bif0.init_busy), 32'd0);
            if (k == 0) chk("noclr fetch_req_ready", 32'(bif0.fetch_req_ready), 32'd1);
            if (k == 1) begin
                chk("noclr fetch_rsp_valid", 32'(bif0.fetch_rsp_valid), 32'd1);
                chk("noclr fetch_rsp_data", bif0.fetch_rsp_data, 32'hA000_0001);
                chk("noclr fetch_rsp_err", 32'(bif0.fetch_rsp_err), 32'd0);
            end
            @(posedge clk);
            #1;
            if (k == 0) bif0.fetch_req_valid = 1'b0;
        end
        step(mk("first_fetch", 1, 32'h0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

        tbl.push_back(mk("wr13",     0, 0,      1, 1, 32'h8,    32'h13,       0, 1, 1, 1, 2));
        tbl.push_back(mk("fetch8",   1, 32'h8,  0, 0, 0,        0,            1, 0, 1, 0, 2));
        tbl.push_back(mk("fetchB",   1, 32'hB,  0, 0, 0,        0,            1, 0, 1, 0, 2));
        tbl.push_back(mk("idle1",    0, 0,      0, 0, 0,        0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("wr_vs_f",  1, 32'h10, 1, 1, 32'h3C,   32'hDEADBEEF, 0, 1, 1, 1, 15));
        tbl.push_back(mk("f_new",    1, 32'h3C, 0, 0, 0,        0,            1, 0, 1, 0, 15));
        tbl.push_back(mk("ld_rd",    0, 0,      1, 0, 32'h3C,   0,            0, 1, 1, 0, 15));
        tbl.push_back(mk("f_oor",    1, 32'h40, 0, 0, 0,        0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("f_oor2",   1, 32'h1000, 0, 0, 0,      0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("ld_oor",   0, 0,      1, 1, 32'h1000, 32'h55,       0, 1, 0, 0, 0));
        tbl.push_back(mk("ld_rd0",   0, 0,      1, 0, 32'h1,    0,            0, 1, 1, 0, 0));
        tbl.push_back(mk("idle2",    0, 0,      0, 0, 0,        0,            0, 0, 0, 0, 0));
        // Both requesters held: four loader grants, then fetch, repeating
        for (int i = 0; i < 10; i++) begin
            f = (i == 4) || (i == 9);
            tbl.push_back(mk("starve", 1, 32'h8, 1, 0, 32'h3C, 0, f, !f, 1, 0, f ? 4'd2 : 4'd15));
        end
        tbl.push_back(mk("idle3",    0, 0,      0, 0, 0,        0,            0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Reset the cycle after a loader read is accepted: the response must be dropped
        step(mk("rst_ld", 0, 0, 1, 0, 32'h3C, 0, 0, 1, 1, 0, 15));
        drive_idle();
        reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
        @(negedge clk);
        chk("midrst ld_rsp_valid", 32'(bif.ld_rsp_valid), 32'd0);
        chk("midrst fetch_rsp_valid", 32'(bif.fetch_rsp_valid), 32'd0);
        chk("midrst init_busy", 32'(bif.init_busy), 32'd1);
        chk("midrst mem_en", 32'(bif.mem_en), 32'd1);
        chk("midrst mem_addr", 32'(bif.mem_addr), 32'd0);
        repeat (int'(DEPTH)) @(posedge clk);
        #1;
        step(mk("post_rst_rd", 0, 0, 1, 0, 32'h3C, 0, 0, 1, 1, 0, 15));
        idle_step("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Shares one single-port synchronous instruction RAM between two requesters: the CPU fetch port (read-only) and a loader/debug port (read/write) used to download programs.
- After reset, optionally sequences a full clear of the RAM.
- Sits between the fetch stage, the loader bridge and the instruction RAM macro.
- Performs word-address translation, range checking, arbitration with a fetch anti-starvation limit, and response routing.

Parameters:
- DEPTH, 1024: RAM depth in 32-bit words.
- AW, 10: word-address width. Must equal log2(DEPTH).
- CLEAR_ON_RESET, 1: 1 = zero every RAM word after reset before serving requests. 0 = serve requests immediately.
- FETCH_STARVE_LIMIT, 4: maximum consecutive loader grants while fetch is waiting. Range 1..15.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req_valid  in  1  fetch read request
- fetch_req_ready  out  1  fetch request accepted this cycle
- fetch_addr  in  32  fetch byte address
- fetch_rsp_valid  out  1  fetch response valid, 1-cycle pulse
- fetch_rsp_data  out  32  instruction word
- fetch_rsp_err  out  1  address out of range
- ld_req_valid  in  1  loader request
- ld_req_ready  out  1  loader request accepted this cycle
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  write data
- ld_rsp_valid  out  1  loader response valid, 1-cycle pulse
- ld_rsp_rdata  out  32  read data (0 for writes and errors)
- ld_rsp_err  out  1  address out of range
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en with mem_we=0
- init_busy  out  1  clear sequence in progress

Behaviour:
- Address mapping:
  - Word address = addr[AW+1:2]. addr[1:0] is ignored, so unaligned addresses truncate to the word.
  - Out of range when addr[31:AW+2] != 0.
- State machine: INIT and RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT:
  - clear_ptr runs 0..DEPTH-1, one word per cycle: mem_en=1, mem_we=1, mem_wdata=0, mem_addr=clear_ptr.
  - After the write to DEPTH-1, moves to RUN. INIT lasts exactly DEPTH cycles.
  - Both readies are 0 and init_busy=1 throughout INIT.
- RUN:
  - At most one grant per cycle. The readies are combinational grants and may depend on the valids. Requesters must not make valid depend on ready.
  - Default priority is loader over fetch.
  - starve_cnt (4 bits):
    - increments on each loader grant while fetch_req_valid=1;
    - clears on a fetch grant;
    - clears whenever fetch_req_valid=0.
  - When starve_cnt==FETCH_STARVE_LIMIT and fetch_req_valid=1, fetch wins over a pending loader request.
- RAM drive:
  - mem_en, mem_we, mem_addr and mem_wdata are combinational from the granted request.
  - An out-of-range grant drives mem_en=0.
  - With no grant, mem_en=0 and mem_we=0.
- Responses:
  - A registered tag (valid, owner, is_write, err) is captured on the grant.
  - The response is asserted exactly 1 cycle after the accept, for one cycle, on the owner's channel only.
  - Read: data = mem_rdata, err=0.
  - Write: rdata=0, err=0. The write is committed to RAM at the accept edge.
  - Error: data=0, err=1, and no RAM access occurs.
  - Response channels have no backpressure.
- Throughput: back-to-back accepts every cycle. A response and a new accept may coincide.
- Simultaneous requests at the same address:
  - A loader write and a fetch to the same address are serialized by arbitration.
  - A fetch granted the cycle after the write returns the new data.
- Reset values:
  - All ready, rsp_valid, rsp_data, rsp_err and mem_* outputs are 0.
  - starve_cnt=0, clear_ptr=0.
  - init_busy = CLEAR_ON_RESET.
- Reset mid-operation: any pending response is dropped (no rsp_valid after the reset cycle), and INIT restarts from address 0.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1, release reset -> init_busy=1 for 16 cycles. mem_we pulses with mem_addr 0..15 and wdata 0. fetch_req_ready stays 0 until cycle 17.
- Loader write 0x00000013 to 0x00000008, then fetch 0x00000008 -> mem_addr=2 on both accesses. ld_rsp_valid 1 cycle after the write accept. fetch_rsp_data=0x00000013 one cycle after the fetch accept. Fetch 0x0000000B also returns 0x00000013.
- Both valids held high, FETCH_STARVE_LIMIT=4 -> grant sequence L,L,L,L,F,L,L,L,L,F.
- AW=10, fetch 0x00001000 -> mem_en=0 that cycle. Next cycle fetch_rsp_valid=1, fetch_rsp_err=1, data=0.
- Loader read accepted, reset asserted the next cycle -> ld_rsp_valid stays 0 after the reset edge. init_busy=1 and mem_addr restarts at 0.
- CLEAR_ON_RESET=0, fetch valid the cycle after reset -> accepted immediately. init_busy=0 throughout.
